// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// A grant lasts until the owner drops its request or has written MAX_BURST words.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    input  logic                     fifo_full,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   winner;
    logic               beat;
    logic               rel;
    logic [WIDTH-1:0]   data_c;

    // Nearest set bit after l wins; l itself is considered only when nothing else is set.
    function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] l);
        logic [IDX_W-1:0] w;
        int               idx;
        w = l;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(l) + k) % N_REQ;
            if (r[idx]) w = IDX_W'(idx);
        end
        return w;
    endfunction

    assign ack        = gnt_q & req & {N_REQ{~fifo_full}};
    assign fifo_wr_en = |ack;
    assign gnt        = gnt_q;
    assign busy       = (state_q == GRANT);
    assign fifo_data  = data_c;

    always_comb begin
        data_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            data_c = data_c | (req_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        winner  = pick(req, last_q);
        beat    = ack[last_q];
        rel     = !req[last_q] || (beat && (cnt_q == LAST_BEAT));
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = ONE << winner;
                    last_d  = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // In GRANT, last_q is the current owner.
                if (rel) begin
                    cnt_d = '0;
                    if (|req) begin
                        gnt_d  = ONE << winner;
                        last_d = winner;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             fifo_full = 1'b0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_data;
    logic             busy;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic         wr;
        logic [W-1:0] data;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   writes = 0;

    // Reference model: who owns the port, who owned it last, words written this tenure
    bit   m_busy = 0;
    int   m_owner = 0;
    int   m_last = N - 1;
    int   m_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    endtask

    // One clock cycle of stimulus: drive, predict outputs, then advance the model past the edge
    task automatic cycle(input logic [N-1:0] r, input logic f);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = r;
        fifo_full = f;
        rand_data();
        e.busy = m_busy;
        e.gnt  = m_busy ? N'(1 << m_owner) : '0;
        e.ack  = (m_busy && r[m_owner] && !f) ? N'(1 << m_owner) : '0;
        e.wr   = (e.ack != 0);
        e.data = m_busy ? req_data[m_owner*W +: W] : '0;
        exp_q.push_back(e);
        if (e.wr) writes++;
        if (!m_busy) begin
            if (r != 0) begin
                m_owner = rr(r, m_last);
                m_last  = m_owner;
                m_cnt   = 0;
                m_busy  = 1;
            end
        end else begin
            if (e.wr) m_cnt++;
            if (!r[m_owner] || (e.wr && m_cnt == BURST)) begin
                m_cnt = 0;
                if (r != 0) begin
                    m_owner = rr(r, m_owner);
                    m_last  = m_owner;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    // Assert reset between edges; outputs must collapse before the next edge
    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req = N'($urandom);
        rand_data();
        m_busy = 0; m_last = N - 1; m_cnt = 0;
        e.gnt = '0; e.ack = '0; e.wr = 1'b0; e.data = '0; e.busy = 1'b0;
        exp_q.push_back(e);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(fifo_data), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("ack", 32'(ack), 32'(e.ack));
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
            chk("fifo_data", 32'(fifo_data), 32'(e.data));
            chk("busy", 32'(busy), 32'(e.busy));
        end
    end

    initial begin
        int w0;
        int i;
        do_reset();
        cycle('0, 1'b0);

        // Everyone requesting: 0,1,2,3,0 in 4-word bursts, no gaps
        cycle(4'b1111, 1'b0);
        w0 = writes;
        for (int k = 0; k < 16; k++) cycle(4'b1111, 1'b0);
        chk("rr_16_writes", 32'(writes - w0), 16);

        // Reset in the middle of requester 2's burst
        for (i = 0; i < 40 && !(m_busy && m_owner == 2 && m_cnt == 1); i++) cycle(4'b1111, 1'b0);
        if (i >= 40) begin
            failures++;
            $display("FAIL mid_burst_setup actual=timeout required=owner2");
        end
        #2;
        chk("pre_rst_gnt", 32'(gnt), 32'h4);
        do_reset();
        for (int k = 0; k < 6; k++) cycle(4'b1111, 1'b0);

        // Early release: requester 0 quits after two words
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        do_reset();
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        for (int k = 0; k < 6; k++) cycle(4'b0010, 1'b0);

        // Full stall during requester 2's tenure
        cycle('0, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        for (int k = 0; k < 5; k++) cycle(4'b0100, 1'b1);
        w0 = writes;
        for (int k = 0; k < 3; k++) cycle(4'b0100, 1'b0);
        chk("stall_resume_writes", 32'(writes - w0), 3);

        // Single requester keeps the port continuously
        cycle('0, 1'b0);
        cycle(4'b1000, 1'b0);
        w0 = writes;
        for (int k = 0; k < 10; k++) cycle(4'b1000, 1'b0);
        chk("single_writes", 32'(writes - w0), 10);

        // Return to idle, then a fresh request
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b0);

        // Random traffic with occasional stalls and resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle(N'($urandom) & N'($urandom | $urandom), $urandom_range(0, 4) == 0);
        end

        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port (wr_en/data_in/full) among N_REQ requesters. Each requester holds a request while it has data; the arbiter grants one requester at a time, lets it write bursts of up to MAX_BURST words, then rotates. It sits directly in front of the storage FIFO and is the only driver of the FIFO write port.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 4, data word width; matches FIFO WIDTH
- MAX_BURST, 4, max accepted words per grant tenure (≥1)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request; bit i high = requester i presents a valid word on its data slice
- req_data  in  N_REQ*WIDTH  requester i word on bits [i*WIDTH +: WIDTH]
- fifo_full  in  1  full flag from the FIFO
- gnt  out  N_REQ  registered one-hot grant (all-zero when idle)
- ack  out  N_REQ  combinational per-requester word accepted this cycle: gnt & req & ~fifo_full
- fifo_wr_en  out  1  combinational: |ack
- fifo_data  out  WIDTH  combinational: req_data slice of the granted requester; 0 when gnt is all-zero
- busy  out  1  registered: high in GRANT state

## Operation
- States: IDLE (gnt=0), GRANT (exactly one gnt bit set). Registers: state, gnt, last owner index `last` (clog2(N_REQ) bits), beat counter `cnt` (clog2(MAX_BURST+1) bits).
- Reset (async, rst_n=0): state=IDLE, gnt=0, busy=0, cnt=0, last=N_REQ-1 (so requester 0 wins the first arbitration). All combinational outputs therefore 0.
- Arbitration pick: scan req from index last+1 upward, wrapping mod N_REQ; first set bit wins. Owner's own bit is scanned last.
- IDLE: if req≠0 at an edge → GRANT, gnt=onehot(winner), last=winner, cnt=0. Else stay.
- GRANT, owner o: a beat is any cycle with ack[o]=1; each beat increments cnt.
- Release condition at an edge: req[o]=0, or (ack[o]=1 and cnt==MAX_BURST-1, i.e. this beat is the MAX_BURST-th).
- On release: if req≠0 (the owner's own req counts only when no other bit is set) → re-arbitrate with last=o, new one-hot gnt next cycle, cnt=0, stay GRANT (no idle bubble). Else → IDLE, gnt=0.
- fifo_full stall: no beat, cnt unchanged, grant held indefinitely while req[o]=1; no timeout.
- req bits of non-owners are ignored for writes; ack for non-owners is always 0.
- Requester contract: keep req and data stable until ack; advance data on the cycle after ack.

## Timing
- Request-to-grant: req sampled at edge t → gnt valid after edge t; first possible write in the cycle following edge t (1-cycle latency).
- Back-to-back: owner with continuous req and no full writes MAX_BURST consecutive cycles; handoff to next requester with zero dead cycles.
- Single requester continuously active: re-granted to itself every MAX_BURST beats, 100% throughput.
- Owner drops req at edge: grant moves at that edge; zero beats lost.
- Simultaneous last-beat and fifo_full rising: beat not accepted (ack=0), no release on count.
- rst_n asserted mid-burst: outputs drop immediately (asynchronously); the interrupted word is not written.
- Counter never exceeds MAX_BURST-1; last is always a valid index < N_REQ.

## Test plan
- Reset: rst_n=0 mid-burst with gnt=4'b0100 → gnt=0, fifo_wr_en=0, busy=0 immediately; after release, req=4'b1111 → gnt=4'b0001 first.
- Round-robin: N_REQ=4, MAX_BURST=4, req=4'b1111 held, full=0 → grants 0,1,2,3,0 each for exactly 4 consecutive writes, no gaps; 16 writes in 16 cycles.
- Early release: req=4'b0011, requester 0 drops req after 2 acks → gnt moves to 4'b0010 the next cycle, requester 1 gets full 4-beat burst.
- Full stall: owner 2 at cnt=1, fifo_full=1 for 5 cycles → ack=0, fifo_wr_en=0, gnt stays 4'b0100, then 3 more beats after full drops (4 total).
- Single requester: only req[3]=1 for 10 cycles → gnt=4'b1000 throughout, 10 writes, busy=1, fifo_data equals req_data[15:12].
- Idle return: all req drop during GRANT → next cycle gnt=0, busy=0, fifo_data=0; re-request of req[1] yields gnt=4'b0010 one cycle later.
